// File: rtl/led_pattern_ctrl.sv
// Commandable status-LED sequencer: steady level, continuous blink or an N-pulse burst.
// Commands arrive over a valid/ready port; every output except io_cmd_ready is registered.
module led_pattern_ctrl #(
  parameter int TICK_DIV = 25000000,
  parameter int PER_W    = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [1:0]       io_cmd_mode,
  input  logic [PER_W-1:0] io_cmd_period,
  input  logic [CNT_W-1:0] io_cmd_count,
  output logic             io_led0,
  output logic             io_busy,
  output logic             io_done
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLINK_HI,
    S_BLINK_LO,
    S_BURST_HI,
    S_BURST_LO
  } state_e;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [PER_W-1:0] ph_q, ph_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] pul_q, pul_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic tick;
  logic ph_end;
  logic accept;

  assign io_cmd_ready = reset &
                        ((state_q == S_IDLE) |
                         (state_q == S_BLINK_HI) |
                         (state_q == S_BLINK_LO));

  assign accept = io_cmd_valid & io_cmd_ready;
  assign tick   = (ps_q == PS_LAST);
  assign ph_end = tick & (ph_q == per_q - PER_W'(1));

  always_comb begin
    state_d = state_q;
    ps_d    = tick ? '0 : ps_q + PS_W'(1);
    ph_d    = ph_q;
    per_d   = per_q;
    pul_d   = pul_q;
    led_d   = led_q;
    done_d  = 1'b0;

    if (accept) begin
      // A new command restarts the timebase and drops any pending toggle.
      ps_d  = '0;
      ph_d  = '0;
      per_d = (io_cmd_period == '0) ? PER_W'(1) : io_cmd_period;
      pul_d = io_cmd_count;
      unique case (io_cmd_mode)
        M_OFF: begin
          state_d = S_IDLE;
          led_d   = 1'b0;
        end
        M_ON: begin
          state_d = S_IDLE;
          led_d   = 1'b1;
        end
        M_BLINK: begin
          state_d = S_BLINK_HI;
          led_d   = 1'b1;
        end
        M_BURST: begin
          if (io_cmd_count == '0) begin
            state_d = S_IDLE;
            led_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_BURST_HI;
            led_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (state_q == S_IDLE) begin
      ph_d = '0;
    end else if (ph_end) begin
      ph_d = '0;
      unique case (state_q)
        S_BLINK_HI: begin
          state_d = S_BLINK_LO;
          led_d   = 1'b0;
        end
        S_BLINK_LO: begin
          state_d = S_BLINK_HI;
          led_d   = 1'b1;
        end
        S_BURST_HI: begin
          state_d = S_BURST_LO;
          led_d   = 1'b0;
        end
        S_BURST_LO: begin
          if (pul_q > CNT_W'(1)) begin
            state_d = S_BURST_HI;
            led_d   = 1'b1;
            pul_d   = pul_q - CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            led_d   = 1'b0;
            pul_d   = '0;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (tick) begin
      ph_d = ph_q + PER_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ps_q    <= '0;
      ph_q    <= '0;
      per_q   <= PER_W'(1);
      pul_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      ph_q    <= ph_d;
      per_q   <= per_d;
      pul_q   <= pul_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io_led0 = led_q;
  assign io_busy = busy_q;
  assign io_done = done_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: LED/busy/done/ready predicted from elapsed
// cycles since the last accepted command.
module tb_led_pattern_ctrl;

  localparam int TD = 4;
  localparam int PW = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          valid = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [PW-1:0] period = '0;
  logic [CW-1:0] count = '0;
  logic          ready, led, busy, done;

  int checks = 0;
  int failures = 0;

  // Reference: last command plus edges elapsed since its accept edge.
  int m_mode = 0;
  int m_per = 1;
  int m_cnt = 0;
  int m_n = 0;
  bit m_static = 1'b0;

  led_pattern_ctrl #(.TICK_DIV(TD), .PER_W(PW), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .io_cmd_valid(valid),
    .io_cmd_ready(ready),
    .io_cmd_mode(mode),
    .io_cmd_period(period),
    .io_cmd_count(count),
    .io_led0(led),
    .io_busy(busy),
    .io_done(done)
  );

  always #5 clock = ~clock;

  function automatic int total();
    return 2 * m_cnt * m_per * TD;
  endfunction

  function automatic bit in_burst();
    return (m_mode == 3) && (m_cnt > 0) && (m_n < total());
  endfunction

  function automatic bit exp_ready();
    return reset && !in_burst();
  endfunction

  function automatic bit exp_led();
    int pt;
    pt = m_per * TD;
    case (m_mode)
      2: return ((m_n / pt) % 2) == 0;
      3: return in_burst() && (((m_n / pt) % 2) == 0);
      default: return m_static;
    endcase
  endfunction

  function automatic bit exp_busy();
    return (m_mode == 2) || in_burst();
  endfunction

  function automatic bit exp_done();
    return (m_mode == 3) && (m_n == total());
  endfunction

  task automatic step();
    bit acc;
    @(posedge clock);
    acc = valid && exp_ready();
    if (!reset) begin
      m_mode = 0;
      m_static = 1'b0;
      m_n = 0;
      m_cnt = 0;
    end else if (acc) begin
      m_mode = int'(mode);
      m_per = (period == 0) ? 1 : int'(period);
      m_cnt = int'(count);
      m_n = 0;
      if (mode == 2'd0) m_static = 1'b0;
      if (mode == 2'd1) m_static = 1'b1;
    end else begin
      m_n++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid = 1'b1;
    mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (led !== 1'b0) begin
        failures++;
        $display("FAIL reset_led got=%b exp=0", led);
      end
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready got=%b exp=0", ready);
      end
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy got=%b exp=0", busy);
      end
    end
    reset = 1'b1;
    valid = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got=%b exp=1", ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (led !== 1'b0) begin
        failures++;
        $display("FAIL release_led got=%b exp=0", led);
      end
    end
  endtask

  task automatic test_on_off();
    valid = 1'b1;
    mode = 2'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      valid = (i == 4);
      mode = 2'd0;
      checks += 2;
      if (led !== exp_led()) begin
        failures++;
        $display("FAIL on_off_led cyc=%0d got=%b exp=%b", i, led, exp_led());
      end
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL on_off_busy cyc=%0d got=%b exp=0", i, busy);
      end
    end
  endtask

  task automatic test_blink();
    valid = 1'b1;
    mode = 2'd2;
    period = 8'd2;
    for (int i = 0; i < 40; i++) begin
      step();
      valid = 1'b0;
      checks += 3;
      if (led !== (((i / 8) % 2) == 0)) begin
        failures++;
        $display("FAIL blink_led cyc=%0d got=%b exp=%b", i, led, ((i / 8) % 2) == 0);
      end
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL blink_busy cyc=%0d got=%b exp=1", i, busy);
      end
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL blink_ready cyc=%0d got=%b exp=1", i, ready);
      end
    end
  endtask

  task automatic test_burst();
    int done_at;
    done_at = -1;
    valid = 1'b1;
    mode = 2'd3;
    period = 8'd1;
    count = 4'd3;
    for (int i = 0; i < 30; i++) begin
      step();
      valid = (i >= 5);
      mode = 2'd1;
      if (done === 1'b1 && done_at < 0) done_at = i;
      checks += 4;
      if (led !== exp_led()) begin
        failures++;
        $display("FAIL burst_led cyc=%0d got=%b exp=%b", i, led, exp_led());
      end
      if (ready !== exp_ready()) begin
        failures++;
        $display("FAIL burst_ready cyc=%0d got=%b exp=%b", i, ready, exp_ready());
      end
      if (done !== exp_done()) begin
        failures++;
        $display("FAIL burst_done cyc=%0d got=%b exp=%b", i, done, exp_done());
      end
      if (busy !== exp_busy()) begin
        failures++;
        $display("FAIL burst_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy());
      end
    end
    valid = 1'b0;
    checks += 2;
    if (done_at != 24) begin
      failures++;
      $display("FAIL burst_done_time got=%0d exp=24", done_at);
    end
    if (led !== 1'b1) begin
      failures++;
      $display("FAIL burst_then_on got=%b exp=1", led);
    end
  endtask

  task automatic test_zero();
    valid = 1'b1;
    mode = 2'd3;
    count = 4'd0;
    step();
    valid = 1'b0;
    checks += 2;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_count_done got=%b exp=1", done);
    end
    if (led !== 1'b0) begin
      failures++;
      $display("FAIL zero_count_led got=%b exp=0", led);
    end
    valid = 1'b1;
    mode = 2'd2;
    period = 8'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      valid = 1'b0;
      checks++;
      if (led !== (((i / 4) % 2) == 0)) begin
        failures++;
        $display("FAIL zero_period_led cyc=%0d got=%b exp=%b", i, led, ((i / 4) % 2) == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    valid = 1'b1;
    mode = 2'd3;
    period = 8'd2;
    count = 4'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      valid = 1'b0;
    end
    reset = 1'b0;
    step();
    checks += 3;
    if (led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b%b%b exp=000", led, busy, done);
    end
    reset = 1'b1;
    #1;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_ready got=%b exp=1", ready);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_no_done cyc=%0d got=%b exp=0", i, done);
      end
    end
  endtask

  task automatic test_preempt();
    valid = 1'b1;
    mode = 2'd2;
    period = 8'd1;
    step();
    valid = 1'b0;
    while (m_n < TD - 1) step();
    valid = 1'b1;
    mode = 2'd1;
    for (int i = 0; i < 12; i++) begin
      step();
      valid = 1'b0;
      checks += 2;
      if (led !== 1'b1) begin
        failures++;
        $display("FAIL preempt_led cyc=%0d got=%b exp=1", i, led);
      end
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL preempt_busy cyc=%0d got=%b exp=0", i, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 15) == 0);
      mode = 2'($urandom_range(0, 3));
      period = PW'($urandom_range(0, 3));
      count = CW'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) != 0);
      #1;
      checks++;
      if (ready !== exp_ready()) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, ready, exp_ready());
      end
      step();
      checks += 3;
      if (led !== exp_led()) begin
        failures++;
        $display("FAIL rand_led cyc=%0d got=%b exp=%b", i, led, exp_led());
      end
      if (busy !== exp_busy()) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy());
      end
      if (done !== exp_done()) begin
        failures++;
        $display("FAIL rand_done cyc=%0d got=%b exp=%b", i, done, exp_done());
      end
    end
    reset = 1'b1;
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_blink();
    test_burst();
    test_zero();
    test_reset_mid();
    test_preempt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
